// File: rtl/multi_tone_gen.sv
// multi_tone_gen: time-multiplexed quadrature tone generator.
// Each channel owns a 16-bit phase accumulator, phase increment and signed
// amplitude. Channels are issued round-robin into a shared three-stage
// pipeline that shapes phase into a parabolic sine approximation. Output is a
// single AXI-Stream of interleaved samples with tlast every spp beats.
// Build option: define MULTI_TONE_QUAD_EN to build the cosine (Q) path;
// without it Q is always 16'h0000 and I timing is unchanged.
module multi_tone_gen #(
   parameter int NUM_CHANNELS      = 4,
   parameter int SR_PHASE_INC_BASE = 129,
   parameter int SR_AMPLITUDE_BASE = 145,
   parameter int SR_SPP_ADDR       = 161,
   parameter int CHAN_W            = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   input  logic              set_stb,
   input  logic [7:0]        set_addr,
   input  logic [31:0]       set_data,
   output logic [31:0]       o_tdata,
   output logic [CHAN_W-1:0] o_tchan,
   output logic              o_tlast,
   output logic              o_tvalid,
   input  logic              o_tready
);

   localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(NUM_CHANNELS - 1);

   // Parabola x*(32768-x) scaled back to 15 bits; peak (x=0x4000) saturates.
   function automatic logic [14:0] parabola(input logic [14:0] x);
      logic [29:0] prod;
      logic [29:0] shifted;
      prod    = 30'(x) * (30'd32768 - 30'(x));
      shifted = prod >> 13;
      return (shifted > 30'd32767) ? 15'h7FFF : shifted[14:0];
   endfunction

   // Amplitude scaling with floor shift, then half-cycle sign flip.
   // |result| never exceeds 32767, so the negation cannot overflow.
   function automatic logic [15:0] scale(input logic [14:0] y,
                                         input logic signed [15:0] a,
                                         input logic neg);
      logic signed [31:0] prod;
      logic signed [15:0] v;
      prod = $signed({17'd0, y}) * $signed({{16{a[15]}}, a});
      v    = 16'(prod >>> 15);
      return neg ? -v : v;
   endfunction

   // ---------------- settings registers ----------------
   logic [15:0]        phase_inc_reg [NUM_CHANNELS];
   logic signed [15:0] amp_reg       [NUM_CHANNELS];
   logic [15:0]        spp_reg;

   logic [8:0]              inc_off;
   logic [8:0]              amp_off;
   logic [NUM_CHANNELS-1:0] inc_hit;
   logic [NUM_CHANNELS-1:0] amp_hit;
   logic                    spp_hit;

   // Offsets are computed 9 bits wide so addresses below a base wrap to a
   // large value and never alias onto a channel.
   assign inc_off = {1'b0, set_addr} - 9'(SR_PHASE_INC_BASE);
   assign amp_off = {1'b0, set_addr} - 9'(SR_AMPLITUDE_BASE);
   assign spp_hit = set_stb && (set_addr == 8'(SR_SPP_ADDR));

   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_decode
         assign inc_hit[gi] = set_stb && (inc_off == 9'(gi));
         assign amp_hit[gi] = set_stb && (amp_off == 9'(gi));
      end
   endgenerate

   // Register file writes; clear leaves these untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            phase_inc_reg[c] <= '0;
            amp_reg[c]       <= '0;
         end
         spp_reg <= 16'd16;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (inc_hit[c]) phase_inc_reg[c] <= set_data[15:0];
            if (amp_hit[c]) amp_reg[c]       <= set_data[15:0];
         end
         if (spp_hit) spp_reg <= set_data[15:0];
      end
   end

   // ---------------- issue ----------------
   logic [15:0] acc_reg [NUM_CHANNELS];
   logic [CHAN_W-1:0] ch_ptr_reg;
   logic [CHAN_W-1:0] ch_ptr_next;
   logic              advance;
   logic              issue;
   logic [15:0]       issue_phase;
   logic [15:0]       issue_inc;
   logic signed [15:0] issue_amp;

   assign advance     = !o_tvalid || o_tready;
   assign issue       = enable && advance && !clear;
   assign issue_phase = acc_reg[ch_ptr_reg];
   assign issue_inc   = phase_inc_reg[ch_ptr_reg];
   assign issue_amp   = amp_reg[ch_ptr_reg];
   assign ch_ptr_next = (ch_ptr_reg == LAST_CH) ? '0 : ch_ptr_reg + 1'b1;

   // Accumulators and channel pointer step only on an actual issue.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int c = 0; c < NUM_CHANNELS; c++) acc_reg[c] <= '0;
         ch_ptr_reg <= '0;
      end else if (issue) begin
         acc_reg[ch_ptr_reg] <= issue_phase + issue_inc;
         ch_ptr_reg          <= ch_ptr_next;
      end
   end

   // ---------------- stage 1: phase / quadrant split ----------------
   logic               s1_valid_reg;
   logic [CHAN_W-1:0]  s1_chan_reg;
   logic               s1_neg_i_reg;
   logic [14:0]        s1_x_i_reg;
   logic signed [15:0] s1_amp_reg;
`ifdef MULTI_TONE_QUAD_EN
   logic               s1_neg_q_reg;
   logic [14:0]        s1_x_q_reg;
   logic [15:0]        issue_phase_q;
   assign issue_phase_q = issue_phase + 16'h4000;
`endif

   // Capture the issued channel's phase and amplitude (old values if a
   // settings write lands on the same edge).
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_reg <= 1'b0;
         s1_chan_reg  <= '0;
         s1_neg_i_reg <= 1'b0;
         s1_x_i_reg   <= '0;
         s1_amp_reg   <= '0;
`ifdef MULTI_TONE_QUAD_EN
         s1_neg_q_reg <= 1'b0;
         s1_x_q_reg   <= '0;
`endif
      end else if (clear) begin
         s1_valid_reg <= 1'b0;
      end else if (advance) begin
         s1_valid_reg <= issue;
         if (issue) begin
            s1_chan_reg  <= ch_ptr_reg;
            s1_neg_i_reg <= issue_phase[15];
            s1_x_i_reg   <= issue_phase[14:0];
            s1_amp_reg   <= issue_amp;
`ifdef MULTI_TONE_QUAD_EN
            s1_neg_q_reg <= issue_phase_q[15];
            s1_x_q_reg   <= issue_phase_q[14:0];
`endif
         end
      end
   end

   // ---------------- stage 2: parabola and saturation ----------------
   logic               s2_valid_reg;
   logic [CHAN_W-1:0]  s2_chan_reg;
   logic               s2_neg_i_reg;
   logic [14:0]        s2_y_i_reg;
   logic signed [15:0] s2_amp_reg;
`ifdef MULTI_TONE_QUAD_EN
   logic               s2_neg_q_reg;
   logic [14:0]        s2_y_q_reg;
`endif

   // Evaluate the unscaled waveform magnitude for each path.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_reg <= 1'b0;
         s2_chan_reg  <= '0;
         s2_neg_i_reg <= 1'b0;
         s2_y_i_reg   <= '0;
         s2_amp_reg   <= '0;
`ifdef MULTI_TONE_QUAD_EN
         s2_neg_q_reg <= 1'b0;
         s2_y_q_reg   <= '0;
`endif
      end else if (clear) begin
         s2_valid_reg <= 1'b0;
      end else if (advance) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_chan_reg  <= s1_chan_reg;
            s2_neg_i_reg <= s1_neg_i_reg;
            s2_y_i_reg   <= parabola(s1_x_i_reg);
            s2_amp_reg   <= s1_amp_reg;
`ifdef MULTI_TONE_QUAD_EN
            s2_neg_q_reg <= s1_neg_q_reg;
            s2_y_q_reg   <= parabola(s1_x_q_reg);
`endif
         end
      end
   end

   // ---------------- stage 3: amplitude, sign, packetisation ----------------
   logic [15:0] i_next;
   logic [15:0] q_next;
   logic [15:0] beat_cnt_reg;
   logic [15:0] spp_latched_reg;
   logic [15:0] cur_spp;
   logic        beat_is_last;

   assign i_next = scale(s2_y_i_reg, s2_amp_reg, s2_neg_i_reg);
`ifdef MULTI_TONE_QUAD_EN
   assign q_next = scale(s2_y_q_reg, s2_amp_reg, s2_neg_q_reg);
`else
   assign q_next = 16'h0000;
`endif

   // beat_cnt_reg counts beats already placed in the current packet. A new
   // beat only enters the output register once the previous one has been
   // accepted, so this equals the accepted-beat count. The first beat of a
   // packet uses the live spp and latches it; spp of 0 or 1 gives tlast on
   // every beat because the compare is >=.
   assign cur_spp      = (beat_cnt_reg == '0) ? spp_reg : spp_latched_reg;
   assign beat_is_last = ({1'b0, beat_cnt_reg} + 17'd1) >= {1'b0, cur_spp};

   // Output register: holds steady while stalled, loads on advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_tvalid        <= 1'b0;
         o_tdata         <= '0;
         o_tchan         <= '0;
         o_tlast         <= 1'b0;
         beat_cnt_reg    <= '0;
         spp_latched_reg <= 16'd16;
      end else if (clear) begin
         o_tvalid     <= 1'b0;
         o_tlast      <= 1'b0;
         beat_cnt_reg <= '0;
      end else if (advance) begin
         o_tvalid <= s2_valid_reg;
         if (s2_valid_reg) begin
            o_tdata      <= {i_next, q_next};
            o_tchan      <= s2_chan_reg;
            o_tlast      <= beat_is_last;
            beat_cnt_reg <= beat_is_last ? '0 : beat_cnt_reg + 1'b1;
            if (beat_cnt_reg == '0) spp_latched_reg <= spp_reg;
         end
      end
   end

endmodule

// File: tb/tb_multi_tone_gen.sv
// Directed bench for multi_tone_gen: a 4-channel instance for interleaving,
// stall, packet and clear behaviour, and a 1-channel instance for the basic
// quadrature waveform and negative-amplitude cases.
module tb_multi_tone_gen;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, clear, enable, enable1, set_stb, o_tready, tready1;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [31:0] tdata,  tdata1;
   logic [1:0]  tchan;
   logic [0:0]  tchan1;
   logic        tlast, tvalid, tlast1, tvalid1;

   int checks = 0;
   int errors = 0;

`ifdef MULTI_TONE_QUAD_EN
   localparam bit QEN = 1'b1;
`else
   localparam bit QEN = 1'b0;
`endif

   multi_tone_gen #(.NUM_CHANNELS(4), .CHAN_W(2)) dut (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .o_tdata(tdata), .o_tchan(tchan), .o_tlast(tlast),
      .o_tvalid(tvalid), .o_tready(o_tready)
   );

   multi_tone_gen #(.NUM_CHANNELS(1), .CHAN_W(1)) dut1 (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable1),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .o_tdata(tdata1), .o_tchan(tchan1), .o_tlast(tlast1),
      .o_tvalid(tvalid1), .o_tready(tready1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = a;
      set_data = d;
      tick();
      set_stb  = 1'b0;
   endtask

   // Reference waveform straight from the formula, used for the long stream.
   function automatic logic [15:0] wave(input logic [15:0] p, input logic [15:0] a);
      longint x, y, sa, v;
      x  = longint'(p[14:0]);
      y  = (x * (32768 - x)) >> 13;
      if (y > 32767) y = 32767;
      sa = longint'($signed(a));
      v  = (y * sa) >>> 15;
      if (p[15]) v = -v;
      return 16'(v);
   endfunction

   function automatic logic [15:0] qsel(input logic [15:0] q);
      return QEN ? q : 16'h0000;
   endfunction

   // Hand-computed tables.
   logic [15:0] d1_i [4] = '{16'h0000, 16'h7FFE, 16'h0000, 16'h8002};
   logic [15:0] d1_q [4] = '{16'h7FFE, 16'h0000, 16'h8002, 16'h0000};
   logic [15:0] d2_i [4] = '{16'h0000, 16'h8001, 16'h0000, 16'h7FFF};
   logic [15:0] d2_q [4] = '{16'h8001, 16'h0000, 16'h7FFF, 16'h0000};
   logic [15:0] a4_i [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                             16'h1C00, 16'h3000, 16'h3C00, 16'h3FFF};
   logic [15:0] a4_q [8] = '{16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h3FFF,
                             16'h3C00, 16'h3000, 16'h1C00, 16'h0000};
   logic        spp_last [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        clr_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      logic [32:0] e33;
      logic [34:0] e35;
      logic [15:0] p, pq;
      int          n, ch, k;
      logic        acc_now, prev_stall;

      reset = 1'b1; clear = 1'b0; enable = 1'b0; enable1 = 1'b0;
      set_stb = 1'b0; set_addr = '0; set_data = '0;
      o_tready = 1'b1; tready1 = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_tvalid", tvalid, 0);
      check("rst_tdata",  tdata,  0);
      check("rst_tchan",  tchan,  0);
      check("rst_tlast",  tlast,  0);
      check("rst_tvalid1", tvalid1, 0);

      // Single-channel quadrature tone; the write to 130 is out of range
      // for the 1-channel instance and must be ignored there.
      write_reg(8'd129, 32'h0000_4000);
      write_reg(8'd145, 32'h0000_7FFF);
      write_reg(8'd161, 32'd4);
      write_reg(8'd130, 32'h0000_1234);
      enable1 = 1'b1;
      tick(); tick();
      check("lat1_early", tvalid1, 0);
      tick();
      check("lat1_valid", tvalid1, 1);
      check("d1_tchan", tchan1, 0);
      for (int b = 0; b < 8; b++) begin
         e33 = {(b % 4 == 3), d1_i[b % 4], qsel(d1_q[b % 4])};
         check($sformatf("d1_beat%0d", b), {tlast1, tdata1}, e33);
         tick();
      end
      enable1 = 1'b0;
      repeat (4) tick();

      // Most negative amplitude: no overflow, sign handled.
      clear = 1'b1; tick(); clear = 1'b0;
      write_reg(8'd145, 32'h0000_8000);
      enable1 = 1'b1;
      repeat (3) tick();
      for (int b = 0; b < 4; b++) begin
         e33 = {(b == 3), d2_i[b], qsel(d2_q[b])};
         check($sformatf("negamp_beat%0d", b), {tlast1, tdata1}, e33);
         tick();
      end
      enable1 = 1'b0;
      repeat (4) tick();

      // Four-channel interleaving.
      for (int c = 0; c < 4; c++) begin
         write_reg(8'(129 + c), 32'(4096 * (c + 1)));
         write_reg(8'(145 + c), 32'h0000_4000);
      end
      enable = 1'b1;
      tick(); tick();
      check("lat4_early", tvalid, 0);
      tick();
      check("lat4_valid", tvalid, 1);
      for (int b = 0; b < 8; b++) begin
         e35 = {2'(b % 4), (b % 4 == 3), a4_i[b], qsel(a4_q[b])};
         check($sformatf("ch4_beat%0d", b), {tchan, tlast, tdata}, e35);
         tick();
      end

      // Random backpressure (~30% stall) and an enable gap; the stream must
      // continue the unstalled sequence beat for beat.
      n = 8;
      prev_stall = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (prev_stall) check($sformatf("stall_hold_valid%0d", n), tvalid, 1);
         if (tvalid) begin
            ch  = n % 4;
            k   = n / 4;
            p   = 16'(k * (ch + 1) * 4096);
            pq  = p + 16'h4000;
            e35 = {2'(ch), (ch == 3), wave(p, 16'h4000), qsel(wave(pq, 16'h4000))};
            check($sformatf("stall_beat%0d", n), {tchan, tlast, tdata}, e35);
         end
         enable     = !(cyc >= 150 && cyc < 170);
         o_tready   = ($urandom_range(0, 99) >= 30);
         acc_now    = tvalid && o_tready;
         prev_stall = tvalid && !o_tready;
         tick();
         if (acc_now) n++;
      end
      check("stall_beats_seen", (n >= 108), 1);

      // Packet length change mid-packet.
      enable = 1'b0;
      o_tready = 1'b1;
      repeat (6) tick();
      check("drain_idle", tvalid, 0);
      clear = 1'b1; tick(); clear = 1'b0;
      write_reg(8'd161, 32'd3);
      enable = 1'b1;
      repeat (3) tick();
      for (int b = 0; b < 8; b++) begin
         check($sformatf("spp_beat%0d", b), {tvalid, tlast}, {1'b1, spp_last[b]});
         if (b == 0) begin
            set_stb = 1'b1; set_addr = 8'd161; set_data = 32'd5;
         end else begin
            set_stb = 1'b0;
         end
         tick();
      end

      // Mid-stream clear with enable held high.
      clear = 1'b1; tick(); clear = 1'b0;
      check("clr_drop", tvalid, 0);
      tick(); tick();
      check("clr_gap", tvalid, 0);
      tick();
      check("clr_restart", tvalid, 1);
      for (int b = 0; b < 6; b++) begin
         e35 = {2'(b % 4), clr_last[b], a4_i[(b / 4) * 4 + b % 4], qsel(a4_q[(b / 4) * 4 + b % 4])};
         check($sformatf("clr_beat%0d", b), {tchan, tlast, tdata}, e35);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
